// File: rtl/vga_scan_out.sv
// Raster timing and pixel output stage: divides clk_50MHz to the pixel rate, generates
// scan position / blanking flags, and registers COLOR onto RGB with one-pixel-delayed syncs.
module vga_scan_out #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk_50MHz,
  input  logic       reset_n,
  input  logic [7:0] COLOR,
  output logic       CLK_DATA,
  output logic [9:0] CURX,
  output logic [8:0] CURY,
  output logic       HBLANK,
  output logic       VBLANK,
  output logic       FRAME_TICK,
  output logic       hs_vga,
  output logic       vs_vga,
  output logic [2:0] RED,
  output logic [2:0] GREEN,
  output logic [1:0] BLUE
);

  localparam int HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(HT - 1);
  localparam logic [9:0] V_LAST   = 10'(VT - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic       clk_data_q, clk_data_d;
  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic       hblank_q, hblank_d;
  logic       vblank_q, vblank_d;
  logic       ftick_q, ftick_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic [7:0] rgb_q, rgb_d;

  logic adv;
  logic h_wrap;
  logic hs_raw, vs_raw;

  // The advance edge is the one where CLK_DATA falls, i.e. while it is currently high.
  assign adv    = clk_data_q;
  assign h_wrap = (hcnt_q == H_LAST);

  // Raw syncs describe the pixel currently on CURX/CURY; they are registered on the
  // next advance so they line up with that pixel's COLOR.
  assign hs_raw = !((hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST));
  assign vs_raw = !((vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST));

  always_comb begin
    clk_data_d = ~clk_data_q;
    hcnt_d     = hcnt_q;
    vcnt_d     = vcnt_q;
    hblank_d   = hblank_q;
    vblank_d   = vblank_q;
    ftick_d    = 1'b0;
    hs_d       = hs_q;
    vs_d       = vs_q;
    rgb_d      = rgb_q;
    if (adv) begin
      if (h_wrap) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
        ftick_d = (vcnt_q == V_VIS - 10'd1);
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
      hblank_d = (hcnt_d >= H_VIS);
      vblank_d = (vcnt_d >= V_VIS);
      hs_d     = hs_raw;
      vs_d     = vs_raw;
      rgb_d    = (hblank_q || vblank_q) ? 8'h00 : COLOR;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (!reset_n) begin
      clk_data_q <= 1'b0;
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      hblank_q   <= 1'b0;
      vblank_q   <= 1'b0;
      ftick_q    <= 1'b0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      rgb_q      <= '0;
    end else begin
      clk_data_q <= clk_data_d;
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      hblank_q   <= hblank_d;
      vblank_q   <= vblank_d;
      ftick_q    <= ftick_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      rgb_q      <= rgb_d;
    end
  end

  assign CLK_DATA   = clk_data_q;
  assign CURX       = hcnt_q;
  assign CURY       = vcnt_q[8:0];
  assign HBLANK     = hblank_q;
  assign VBLANK     = vblank_q;
  assign FRAME_TICK = ftick_q;
  assign hs_vga     = hs_q;
  assign vs_vga     = vs_q;
  assign RED        = rgb_q[7:5];
  assign GREEN      = rgb_q[4:2];
  assign BLUE       = rgb_q[1:0];

endmodule

// File: tb/tb_vga_scan_out.sv
// Bench for vga_scan_out on a shrunken raster: a closed-form model of the scan (from the
// cycle count since reset release) feeds a scoreboard that is checked every cycle.
module tb_vga_scan_out;
  localparam int HV = 24, HF = 4, HS = 6, HB = 6;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

  logic       clk_50MHz = 1'b0;
  logic       reset_n   = 1'b0;
  logic [7:0] COLOR     = 8'h00;
  logic       CLK_DATA, HBLANK, VBLANK, FRAME_TICK, hs_vga, vs_vga;
  logic [9:0] CURX;
  logic [8:0] CURY;
  logic [2:0] RED, GREEN;
  logic [1:0] BLUE;

  vga_scan_out #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk_50MHz(clk_50MHz), .reset_n(reset_n), .COLOR(COLOR),
    .CLK_DATA(CLK_DATA), .CURX(CURX), .CURY(CURY),
    .HBLANK(HBLANK), .VBLANK(VBLANK), .FRAME_TICK(FRAME_TICK),
    .hs_vga(hs_vga), .vs_vga(vs_vga),
    .RED(RED), .GREEN(GREEN), .BLUE(BLUE)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  typedef struct packed {
    logic       clk;
    logic [9:0] x;
    logic [8:0] y;
    logic       hb, vb, ft, hs, vs;
    logic [7:0] rgb;
  } obs_t;

  obs_t       sb_q[$];
  int         total = 0, bad = 0;
  int         t = 0;
  longint     cyc = 0;
  longint     hs_fall = -1, vs_fall = -1;
  logic       prev_hs = 1'b1, prev_vs = 1'b1, prev_ft = 1'b0;
  logic [7:0] exp_rgb = 8'h00;
  int         ticks = 0;

  function automatic logic vis(int p);
    return ((p % HT) < HV) && (((p / HT) % VT) < VV);
  endfunction

  function automatic obs_t model(int tt, logic [7:0] rgb);
    obs_t m;
    int p, h, v, ph, pv;
    p = tt / 2;
    h = p % HT;
    v = (p / HT) % VT;
    m.clk = (tt % 2 == 1);
    m.x   = 10'(h);
    m.y   = 9'(v);
    m.hb  = (h >= HV);
    m.vb  = (v >= VV);
    m.ft  = (tt > 0) && (tt % 2 == 0) && (h == 0) && (v == VV);
    if (p == 0) begin
      m.hs = 1'b1;
      m.vs = 1'b1;
    end else begin
      ph = (p - 1) % HT;
      pv = ((p - 1) / HT) % VT;
      m.hs = !(ph >= HV + HF && ph < HV + HF + HS);
      m.vs = !(pv >= VV + VF && pv < VV + VF + VS);
    end
    m.rgb = rgb;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // One clock: push the model's expectation at the edge, compare at the falling edge.
  task automatic step();
    obs_t e, o;
    @(posedge clk_50MHz);
    cyc++;
    if (!reset_n) begin
      t = 0;
      exp_rgb = 8'h00;
      hs_fall = -1;
      vs_fall = -1;
    end else begin
      t++;
      if (t % 2 == 0) exp_rgb = vis(t / 2 - 1) ? COLOR : 8'h00;
    end
    sb_q.push_back(model(t, exp_rgb));
    @(negedge clk_50MHz);
    e = sb_q.pop_front();
    o = {CLK_DATA, CURX, CURY, HBLANK, VBLANK, FRAME_TICK, hs_vga, vs_vga, RED, GREEN, BLUE};
    chk("outputs", 64'(o), 64'(e));
    if (prev_hs && !hs_vga) begin
      if (hs_fall >= 0) chk("hs_period", 64'(cyc - hs_fall), 64'(2 * HT));
      hs_fall = cyc;
    end
    if (!prev_hs && hs_vga && hs_fall >= 0) chk("hs_low", 64'(cyc - hs_fall), 64'(2 * HS));
    if (prev_vs && !vs_vga) begin
      if (vs_fall >= 0) chk("vs_period", 64'(cyc - vs_fall), 64'(2 * HT * VT));
      vs_fall = cyc;
    end
    if (!prev_vs && vs_vga && vs_fall >= 0) chk("vs_low", 64'(cyc - vs_fall), 64'(2 * HT * VS));
    if (FRAME_TICK) begin
      ticks++;
      chk("tick_pos", 64'({VBLANK, CURY, CURX, prev_ft}), 64'({1'b1, 9'(VV), 10'd0, 1'b0}));
    end
    prev_hs = hs_vga;
    prev_vs = vs_vga;
    prev_ft = FRAME_TICK;
  endtask

  initial begin
    int n_run, exp_ticks, tn, h, v;
    bit found;

    // Reset with COLOR driven high.
    reset_n = 1'b0;
    COLOR   = 8'hFF;
    repeat (5) step();

    // Colour gating plus line/frame timing over two frames.
    reset_n = 1'b1;
    COLOR   = 8'b11111100;
    n_run   = 2 * 2 * HT * VT + 200;
    repeat (n_run) step();
    exp_ticks = 0;
    for (int k = 0; 2 * VV * HT + k * 2 * HT * VT <= n_run; k++) exp_ticks++;
    chk("tick_count", 64'(ticks), 64'(exp_ticks));

    // Pixel alignment: COLOR carries the x of the pixel being retired on the next advance.
    for (int i = 0; i < 2 * HT * VT; i++) begin
      tn = t + 1;
      COLOR = 8'(((tn / 2) + HT - 1) % HT);
      step();
    end

    // Mid-frame reset at x=10, y=3.
    found = 1'b0;
    COLOR = 8'b11111100;
    for (int i = 0; i < 2 * HT * VT + 4; i++) begin
      h = (t / 2) % HT;
      v = ((t / 2) / HT) % VT;
      if (h == 10 && v == 3 && t % 2 == 0) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("find_mid_point", 64'(found), 64'(1));
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (3 * 2 * HT + 10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
